rgb_cmd_ctrl: RTL
=================

# rgb_cmd_ctrl

Command controller for the RGB LED path. Consumes the byte stream from the UART receiver as single-cycle `rx_valid` strobes and parses one- and two-byte commands. Holds per-channel duty and blink configuration, and drives `LED[2:0]` through an internal 8-bit PWM with an optional blink gate. It sits between the UART receiver and the LED pins inside `Top`.

## Interface
- `PWM_DIV`, default 4: clock cycles per PWM step; must be ≥1.
- `BLINK_TICK`, default 100_000: clock cycles per blink time unit; must be ≥1.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum wait for an argument byte; must be ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte; meaningful only while `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe; every strobe is consumed, with no backpressure.
- `LED` out 3: bit 0 is R, bit 1 is G, bit 2 is B; registered.
- `cmd_ack` out 1: one-cycle pulse when a command has been applied.
- `cmd_err` out 1: one-cycle pulse on an unknown opcode or an argument timeout.

## Operation
- Opcodes (byte 0):
  - 0x52 'R', 0x47 'G', 0x42 'B': set duty of channel 0, 1 or 2 to the argument byte.
  - 0x4B 'K': set `blink_half` to the argument byte.
  - 0x58 'X': single-byte command; clears all duties and `blink_half` to 0.
  - Any other byte in IDLE: unknown opcode.
- FSM states: IDLE and WAIT_ARG.
  - IDLE, valid two-byte opcode: latch the channel/target, clear the timeout counter, go to WAIT_ARG.
  - IDLE, 'X': apply, pulse `cmd_ack`, stay in IDLE.
  - IDLE, unknown opcode: pulse `cmd_err`, stay in IDLE; no register changes.
  - WAIT_ARG, `rx_valid`: the byte is the argument, whatever its value (0x52 is data here). Write the target register, pulse `cmd_ack`, go to IDLE.
  - WAIT_ARG, no `rx_valid`: the timeout counter increments. When it reaches TIMEOUT_CYCLES-1, pulse `cmd_err`, go to IDLE, discard the opcode.
  - Simultaneous: `rx_valid` in the expiry cycle wins. The byte is accepted as the argument, with `cmd_ack` and no `cmd_err`.
- PWM:
  - A prescaler counts 0..PWM_DIV-1.
  - On each prescaler wrap, the 8-bit `pwm_cnt` increments, wrapping 255→0.
  - Channel c is on when `pwm_cnt < duty[c]`. Duty 0 means always off; duty 255 means on 255 of 256 steps.
- Blink:
  - When `blink_half` is 0, the blink gate is permanently on.
  - Otherwise a tick prescaler counts 0..BLINK_TICK-1. On each tick, `half_cnt` increments. When a tick arrives with `half_cnt == blink_half-1`, the gate toggles and `half_cnt` clears.
  - Any 'K' or 'X' write clears the tick prescaler and `half_cnt`, and forces the gate on.
- Output: `LED[c]` is registered as gate AND PWM compare.
- Duty writes take effect on the next PWM compare. The PWM counter is never reset by commands.

## Timing
- Reset values:
  - `LED`=000, `cmd_ack`=0, `cmd_err`=0.
  - All duties 0, `blink_half`=0, gate on.
  - FSM in IDLE; all counters 0.
- Reset asserted mid-command (in WAIT_ARG) returns everything to the reset values on the next edge. No ack or err is issued for the aborted command.
- Opcode strobe at edge N: state is WAIT_ARG after edge N.
- Argument strobe at edge M:
  - Register updated and `cmd_ack` high during M+1 (one cycle only).
  - `LED` reflects the new duty from M+2.
- 'X' or unknown opcode at edge N: `cmd_ack` or `cmd_err` respectively is high during N+1.
- Timeout: `cmd_err` is high exactly TIMEOUT_CYCLES cycles after the opcode edge when no argument arrives.
- `cmd_ack` and `cmd_err` are never high in the same cycle.
- Back-to-back strobes on consecutive cycles are all handled without loss.
- PWM period is 256·PWM_DIV cycles. A full blink cycle is 2·blink_half·BLINK_TICK cycles.

## Test plan
Sim parameters for all scenarios: PWM_DIV=1, BLINK_TICK=4, TIMEOUT_CYCLES=100.

1. Reset, then hold idle for 600 cycles → `LED`=000 throughout; `cmd_ack` and `cmd_err` never high.
2. Send 0x52,0x40 then 0x42,0xFF → one `cmd_ack` pulse per command. `LED[0]` high 64 of every 256 cycles. `LED[2]` high 255 of every 256 cycles. `LED[1]` stays 0.
3. Send 0x47,0x80 then 0x4B,0x02 → `LED[1]` PWM output is gated on for 8 cycles, then off for 8 cycles, repeating. Follow with 0x58 → `cmd_ack`, then `LED`=000.
4. Send 0x5F, then 0x2A → two `cmd_err` pulses, no `cmd_ack`, all registers unchanged.
5. Send 0x52 and nothing else → `cmd_err` pulses 100 cycles after the opcode, FSM returns to IDLE. A following 0x7A gives `cmd_err` (treated as an opcode, not an argument). Repeat with the argument strobe landing exactly in the expiry cycle → `cmd_ack` only, and the duty is updated.
6. Send 0x52, then assert `rst` before the argument; after release send 0x10 → `cmd_err` (0x10 is parsed as an opcode). Duty R remains 0 and `LED`=000.

Source files
------------

// File: rtl/rgb_cmd_ctrl.sv
// Parses one/two-byte UART commands into per-channel duty and blink settings, and drives LED[2:0] via an 8-bit PWM with a blink gate.
// Latency: ack/err one cycle after the strobe; LED follows a duty write one cycle later. No backpressure: every strobe is consumed.
module rgb_cmd_ctrl #(
    parameter int PWM_DIV        = 4,
    parameter int BLINK_TICK     = 100_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [2:0] LED,
    output logic       cmd_ack,
    output logic       cmd_err
);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BW = (BLINK_TICK > 1) ? $clog2(BLINK_TICK) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] TGT_BLINK = 2'd3;

    typedef enum logic {IDLE, WAIT_ARG} state_t;

    state_t        state_q, state_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ack_d, err_d, wr_en, clr_all;

    logic [7:0]    duty [3];
    logic [7:0]    blink_half;
    logic [PW-1:0] pwm_pre;
    logic [7:0]    pwm_cnt;
    logic [BW-1:0] blink_pre;
    logic [7:0]    half_cnt;
    logic          gate;
    logic          blink_upd;
    logic [2:0]    led_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= 2'd0;
            tcnt_q  <= '0;
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            tcnt_q  <= tcnt_d;
            cmd_ack <= ack_d;
            cmd_err <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        tcnt_d  = tcnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        clr_all = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h52, 8'h47, 8'h42, 8'h4B: begin
                            case (rx_data)
                                8'h52:   tgt_d = 2'd0;
                                8'h47:   tgt_d = 2'd1;
                                8'h42:   tgt_d = 2'd2;
                                default: tgt_d = TGT_BLINK;
                            endcase
                            tcnt_d  = '0;
                            state_d = WAIT_ARG;
                        end
                        8'h58: begin
                            clr_all = 1'b1;
                            ack_d   = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            WAIT_ARG: begin
                // An argument arriving in the expiry cycle takes priority over the timeout.
                if (rx_valid) begin
                    wr_en   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 2)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign blink_upd = clr_all || (wr_en && tgt_q == TGT_BLINK);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) duty[c] <= 8'd0;
            blink_half <= 8'd0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (clr_all) duty[c] <= 8'd0;
                else if (wr_en && tgt_q == 2'(c)) duty[c] <= rx_data;
            end
            if (clr_all) blink_half <= 8'd0;
            else if (wr_en && tgt_q == TGT_BLINK) blink_half <= rx_data;
        end
    end

    // PWM counter free-runs; commands never disturb its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_pre <= '0;
            pwm_cnt <= 8'd0;
        end else if (pwm_pre == PW'(PWM_DIV - 1)) begin
            pwm_pre <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pwm_pre <= pwm_pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || blink_upd) begin
            blink_pre <= '0;
            half_cnt  <= 8'd0;
            gate      <= 1'b1;
        end else if (blink_half != 8'd0) begin
            if (blink_pre == BW'(BLINK_TICK - 1)) begin
                blink_pre <= '0;
                if (half_cnt == blink_half - 8'd1) begin
                    gate     <= ~gate;
                    half_cnt <= 8'd0;
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end else begin
                blink_pre <= blink_pre + 1'b1;
            end
        end
    end

    always_comb begin
        led_d = 3'b000;
        for (int c = 0; c < 3; c++) led_d[c] = gate && (pwm_cnt < duty[c]);
    end

    always_ff @(posedge clk) begin
        if (rst) LED <= 3'b000;
        else     LED <= led_d;
    end
endmodule
